// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-port memory bus arbiter.
// Also used by the set cache for its burst length.
package mem_arb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int BEATS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// reqcyc/reqack/respcyc/respack bus bundle.
// master drives requests; slave returns responses.
interface mem_bus_arbiter_if #(
  parameter int DW = 64,
  parameter int TW = 13
);
  logic          bus_reqcyc;
  logic          bus_reqack;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_respcyc;
  logic          bus_respack;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the port
// that did not win last time is chosen.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_i,
  output logic       valid_o,
  output req_id_t    id_o
);

  assign valid_o = |req_i;

  always_comb begin
    id_o = 1'b0;
    unique case (req_i)
      2'b01:   id_o = 1'b0;
      2'b10:   id_o = 1'b1;
      2'b11:   id_o = ~last_i;
      default: id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one DRAM bus between icache (p0) and dcache (p1),
// holding the grant for a whole response burst.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = BEATS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   p0,
  mem_bus_arbiter_if.slave   p1,
  mem_bus_arbiter_if.master  m,
  output logic [1:0]         grant,
  output logic               tag_err
);

  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_e             state_q, state_d;
  req_id_t            owner_q, owner_d;
  req_id_t            last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
  logic               terr_q, terr_d;

  logic               pick_v;
  req_id_t            pick_id;

  logic                      own_reqcyc;
  logic                      own_respack;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      beat;

  rr_pick2 u_pick (
    .req_i   ({p1.bus_reqcyc, p0.bus_reqcyc}),
    .last_i  (last_q),
    .valid_o (pick_v),
    .id_o    (pick_id)
  );

  assign own_reqcyc  = owner_q ? p1.bus_reqcyc  : p0.bus_reqcyc;
  assign own_respack = owner_q ? p1.bus_respack : p0.bus_respack;
  assign own_req     = owner_q ? p1.bus_req     : p0.bus_req;
  assign own_reqtag  = owner_q ? p1.bus_reqtag  : p0.bus_reqtag;

  assign beat = (state_q == RESP) & m.bus_respcyc & own_respack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tag_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_v) begin
          owner_d = pick_id;
          last_d  = pick_id;
          tag_d   = pick_id ? p1.bus_reqtag : p0.bus_reqtag;
          state_d = REQ;
        end
      end
      REQ: begin
        // a withdrawn request wins over a same-cycle ack
        if (!own_reqcyc) begin
          state_d = IDLE;
        end else if (m.bus_reqack) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (m.bus_resptag != tag_q) terr_d = 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant          = 2'b00;
    m.bus_reqcyc   = 1'b0;
    m.bus_req      = '0;
    m.bus_reqtag   = '0;
    m.bus_respack  = 1'b0;
    p0.bus_reqack  = 1'b0;
    p0.bus_respcyc = 1'b0;
    p0.bus_resp    = '0;
    p0.bus_resptag = '0;
    p1.bus_reqack  = 1'b0;
    p1.bus_respcyc = 1'b0;
    p1.bus_resp    = '0;
    p1.bus_resptag = '0;
    if (state_q != IDLE) grant = owner_q ? 2'b10 : 2'b01;
    if (state_q == REQ) begin
      m.bus_reqcyc = own_reqcyc;
      m.bus_req    = own_req;
      m.bus_reqtag = own_reqtag;
      if (owner_q) p1.bus_reqack = m.bus_reqack;
      else         p0.bus_reqack = m.bus_reqack;
    end
    if (state_q == RESP) begin
      m.bus_respack = own_respack;
      if (owner_q) begin
        p1.bus_respcyc = m.bus_respcyc;
        p1.bus_resp    = m.bus_resp;
        p1.bus_resptag = m.bus_resptag;
      end else begin
        p0.bus_respcyc = m.bus_respcyc;
        p0.bus_resp    = m.bus_resp;
        p0.bus_resptag = m.bus_resptag;
      end
    end
  end

  assign tag_err = terr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table
// for a single burst plus hand-written burst sequences.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 64;
  localparam int TW = 13;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] grant;
  logic       tag_err;

  mem_bus_arbiter_if #(.DW(DW), .TW(TW)) p0_if ();
  mem_bus_arbiter_if #(.DW(DW), .TW(TW)) p1_if ();
  mem_bus_arbiter_if #(.DW(DW), .TW(TW)) m_if ();

  mem_bus_arbiter #(
    .BUS_DATA_WIDTH (DW),
    .BUS_TAG_WIDTH  (TW),
    .BEATS          (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .p0      (p0_if),
    .p1      (p1_if),
    .m       (m_if),
    .grant   (grant),
    .tag_err (tag_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1, mack, mrc;
    logic [63:0] d;
    logic [1:0]  g;
    logic [6:0]  fl;
    logic [63:0] ed;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total = 0;
  bit   keep_req = 1'b0;

  function automatic vec_t mk(logic r0, logic r1, logic mack,
                              logic mrc, logic [63:0] d,
                              logic [1:0] g, logic [6:0] fl,
                              logic [63:0] ed);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.mack = mack; v.mrc = mrc;
    v.d = d; v.g = g; v.fl = fl; v.ed = ed;
    return v;
  endfunction

  function automatic void chk(string n, logic [63:0] a,
                              logic [63:0] e);
    total++;
    if (a !== e)
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    else
      passed++;
  endfunction

  function automatic logic [6:0] flags();
    return {p0_if.bus_reqack, p1_if.bus_reqack,
            m_if.bus_reqcyc, p0_if.bus_respcyc,
            p1_if.bus_respcyc, m_if.bus_respack, tag_err};
  endfunction

  function automatic logic rc(int p);
    return (p == 0) ? p0_if.bus_respcyc : p1_if.bus_respcyc;
  endfunction

  function automatic logic [63:0] resp_of(int p);
    return (p == 0) ? p0_if.bus_resp : p1_if.bus_resp;
  endfunction

  task automatic set_req(int p, logic v, logic [12:0] tg);
    if (p == 0) begin
      p0_if.bus_reqcyc = v;
      p0_if.bus_reqtag = tg;
      p0_if.bus_req    = 64'(tg) << 8;
    end else begin
      p1_if.bus_reqcyc = v;
      p1_if.bus_reqtag = tg;
      p1_if.bus_req    = 64'(tg) << 8;
    end
  endtask

  task automatic set_ack(int p, logic v);
    if (p == 0) p0_if.bus_respack = v;
    else        p1_if.bus_respack = v;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // called at a negedge with the requester already asserted
  task automatic burst(int p, logic [12:0] tg, int exp_wait,
                       int stall_at, int stall_len,
                       int bad_at, int abort_at);
    int          w;
    logic [63:0] d;
    logic [1:0]  gexp;
    w = 0;
    gexp = (p == 0) ? 2'b01 : 2'b10;
    #1;
    while (grant !== gexp && w < 8) begin
      tick();
      #1;
      w++;
    end
    chk("grant_wait", 64'(w), 64'(exp_wait));
    m_if.bus_reqack = 1'b1;
    #1;
    chk("reqack", {63'd0, p == 0 ? p0_if.bus_reqack
                                 : p1_if.bus_reqack}, 64'd1);
    chk("m_reqtag", 64'(m_if.bus_reqtag), 64'(tg));
    chk("m_req", m_if.bus_req, 64'(tg) << 8);
    tick();
    m_if.bus_reqack = 1'b0;
    if (!keep_req) set_req(p, 1'b0, tg);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_at) return;
      d = 64'(p * 256 + 'hB0 + i);
      m_if.bus_respcyc = 1'b1;
      m_if.bus_resp    = d;
      m_if.bus_resptag = (i == bad_at) ? 13'd7 : tg;
      if (i == stall_at) begin
        set_ack(p, 1'b0);
        for (int s = 0; s < stall_len; s++) begin
          #1;
          chk("stall_respack", {63'd0, m_if.bus_respack}, 64'd0);
          chk("stall_respcyc", {63'd0, rc(p)}, 64'd1);
          tick();
        end
        set_ack(p, 1'b1);
      end
      #1;
      chk("beat_data", resp_of(p), d);
      chk("beat_flags", {61'd0, rc(p), rc(1 - p),
                         m_if.bus_respack}, 64'b101);
      if (i == bad_at)
        chk("terr_pre", {63'd0, tag_err}, 64'd0);
      tick();
      if (i == bad_at) begin
        #1;
        chk("terr_post", {63'd0, tag_err}, 64'd1);
      end
    end
    m_if.bus_respcyc = 1'b0;
    #1;
    chk("end_grant", 64'(grant), 64'd0);
  endtask

  initial begin
    p0_if.bus_reqcyc = 0; p0_if.bus_req = 0;
    p0_if.bus_reqtag = 0; p0_if.bus_respack = 1;
    p1_if.bus_reqcyc = 0; p1_if.bus_req = 64'h9999;
    p1_if.bus_reqtag = 13'd3; p1_if.bus_respack = 1;
    m_if.bus_reqack = 0; m_if.bus_respcyc = 0;
    m_if.bus_resp = 0; m_if.bus_resptag = 0;

    // single p0 burst, memory acks on the third REQ cycle
    vq.push_back(mk(1, 0, 0, 0, 0, 2'b00, 7'b0000000, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 2'b01, 7'b0010000, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 2'b01, 7'b0010000, 0));
    vq.push_back(mk(1, 0, 1, 0, 0, 2'b01, 7'b1010000, 0));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, (i >= 1 && i <= 4), 0, 1,
                      64'hA0 + 64'(i), 2'b01, 7'b0001010,
                      64'hA0 + 64'(i)));
    vq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 7'b0000000, 0));

    #1;
    chk("reset_out", {55'd0, grant, flags()}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    p0_if.bus_req = 64'h1000;
    p0_if.bus_reqtag = 13'd5;
    m_if.bus_resptag = 13'd5;
    for (int k = 0; k < vq.size(); k++) begin
      p0_if.bus_reqcyc = vq[k].r0;
      p1_if.bus_reqcyc = vq[k].r1;
      m_if.bus_reqack  = vq[k].mack;
      m_if.bus_respcyc = vq[k].mrc;
      m_if.bus_resp    = vq[k].d;
      #1;
      chk("t1_grant", 64'(grant), 64'(vq[k].g));
      chk("t1_flags", 64'(flags()), 64'(vq[k].fl));
      chk("t1_p0resp", p0_if.bus_resp, vq[k].ed);
      chk("t1_p1resp", p1_if.bus_resp, 64'd0);
      chk("t1_mreq", m_if.bus_req,
          vq[k].fl[4] ? 64'h1000 : 64'd0);
      tick();
    end

    // both requesting out of reset: alternate 0,1,0,1
    reset = 1'b0;
    set_req(0, 1'b1, 13'h10);
    set_req(1, 1'b1, 13'h11);
    #1;
    chk("rst_req_out", {55'd0, grant, flags()}, 64'd0);
    tick();
    reset = 1'b1;
    keep_req = 1'b1;
    burst(0, 13'h10, 1, -1, 0, -1, -1);
    burst(1, 13'h11, 1, -1, 0, -1, -1);
    burst(0, 13'h10, 1, -1, 0, -1, -1);
    burst(1, 13'h11, 1, -1, 0, -1, -1);
    set_req(0, 1'b0, 13'h10);
    set_req(1, 1'b0, 13'h11);
    keep_req = 1'b0;
    tick();

    // p1 stalls beat 3 for 5 cycles
    set_req(1, 1'b1, 13'h22);
    burst(1, 13'h22, 1, 3, 5, -1, -1);
    tick();

    // wrong tag on beat 2; error is sticky
    set_req(0, 1'b1, 13'h4);
    burst(0, 13'h4, 1, -1, 0, 2, -1);
    tick();
    set_req(1, 1'b1, 13'h44);
    burst(1, 13'h44, 1, -1, 0, -1, -1);
    chk("terr_sticky", {63'd0, tag_err}, 64'd1);
    tick();

    // reset in the middle of beat 4
    set_req(0, 1'b1, 13'h9);
    burst(0, 13'h9, 1, -1, 0, -1, 4);
    m_if.bus_respcyc = 1'b1;
    m_if.bus_resp = 64'hDEAD;
    m_if.bus_resptag = 13'h9;
    set_req(0, 1'b1, 13'h9);
    set_req(1, 1'b1, 13'h33);
    #1;
    chk("mid_respcyc", {63'd0, p0_if.bus_respcyc}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", {55'd0, grant, flags()}, 64'd0);
    chk("async_rst_resp", p0_if.bus_resp, 64'd0);
    m_if.bus_respcyc = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_idle", 64'(grant), 64'd0);
    tick();
    #1;
    chk("post_rst_grant", 64'(grant), 64'b01);

    // p0 withdraws in REQ as memory acks
    p0_if.bus_reqcyc = 1'b0;
    m_if.bus_reqack = 1'b1;
    #1;
    chk("drop_mreqcyc", {63'd0, m_if.bus_reqcyc}, 64'd0);
    chk("drop_grant", 64'(grant), 64'b01);
    tick();
    m_if.bus_reqack = 1'b0;
    m_if.bus_respcyc = 1'b1;
    #1;
    chk("drop_idle", {55'd0, grant, flags()}, 64'd0);
    m_if.bus_respcyc = 1'b0;
    burst(1, 13'h33, 1, -1, 0, -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single DRAM-side memory bus between two cache requesters: port 0 is the instruction cache and port 1 is the data cache, both instances of the set cache. Each requester speaks the standard reqcyc/reqack/respcyc/respack bus protocol. The arbiter grants one requester at a time with round-robin priority. It forwards the request to memory and routes every response beat of the burst back to the winner, holding the grant until the burst finishes.

Parameters:
BUS_DATA_WIDTH, 64, address/data width of every bus port.
BUS_TAG_WIDTH, 13, request/response tag width.
BEATS, 8, response beats per transaction (512-bit line / 64-bit beats).

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset (0 = in reset).
pN_bus_reqcyc  in  1  (N=0,1) requester N request valid.
pN_bus_reqack  out  1  request accepted by memory, forwarded to requester N.
pN_bus_req  in  BUS_DATA_WIDTH  requester N address.
pN_bus_reqtag  in  BUS_TAG_WIDTH  requester N tag.
pN_bus_respcyc  out  1  response beat valid to requester N.
pN_bus_respack  in  1  requester N accepts beat.
pN_bus_resp  out  BUS_DATA_WIDTH  response data to requester N.
pN_bus_resptag  out  BUS_TAG_WIDTH  response tag to requester N.
m_bus_reqcyc/m_bus_req/m_bus_reqtag  out  1/BUS_DATA_WIDTH/BUS_TAG_WIDTH  memory request.
m_bus_reqack  in  1  memory accepted request.
m_bus_respcyc/m_bus_resp/m_bus_resptag  in  1/BUS_DATA_WIDTH/BUS_TAG_WIDTH  memory response beat.
m_bus_respack  out  1  beat accepted.
grant  out  2  one-hot current owner (bit N = port N); 0 when idle.
tag_err  out  1  sticky: a response tag differed from the granted request tag.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, owner=none, last_grant=1 (so port 0 wins the first tie), beat_cnt=0, tag_err=0.
  - All outputs 0 immediately, including during reset.
  - Reset mid-transaction abandons the burst; no further beats are forwarded.
- State machine: IDLE -> REQ -> RESP -> IDLE.
- IDLE:
  - All outputs 0.
  - If exactly one reqcyc is high, grant that port. If both are high, grant the port != last_grant.
  - On a grant: latch owner, latch the owner's reqtag into saved_tag, set last_grant=owner, go to REQ.
  - Arbitration costs exactly 1 cycle.
- REQ (combinational pass-through from owner):
  - m_bus_reqcyc = pOwner_reqcyc; m_bus_req and m_bus_reqtag come from the owner; pOwner_reqack = m_bus_reqack.
  - m_bus_reqack & pOwner_reqcyc -> RESP, beat_cnt=0.
  - pOwner_reqcyc drops before the ack -> IDLE; the request is abandoned and last_grant stays updated.
- RESP:
  - pOwner_respcyc = m_bus_respcyc; pOwner_resp and pOwner_resptag come from the m side; m_bus_respack = pOwner_respack.
  - A beat completes when m_bus_respcyc & pOwner_respack.
  - Each beat: beat_cnt++. If m_bus_resptag != saved_tag, set tag_err=1; the data is still forwarded.
  - Beat with beat_cnt==BEATS-1 -> IDLE, beat_cnt=0. BEATS and BEATS-1 must fit the counter width ($clog2(BEATS)+1).
- Non-owner port: all outputs held 0; its reqcyc is ignored and it waits (no queueing inside the arbiter).
- grant = one-hot owner in REQ/RESP, 0 in IDLE.
- Simultaneous events:
  - A new reqcyc in the same cycle as the final beat is not seen until the next IDLE cycle, so there is a minimum 1-cycle bubble between bursts.
  - Memory reqack in the same cycle the owner drops reqcyc: the drop wins (-> IDLE, m_bus_reqcyc already 0).
- No starvation: with continuous requests on both ports, grants alternate 0,1,0,1.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, REQ, RESP).
  - requester-id type (1 bit), NUM_REQ=2.
  - Default BEATS constant shared with the cache.
- Optional sub-module rr_pick2: combinational 2-way round-robin pick from (req[1:0], last_grant) to (valid, id).
- The rest stays flat, with one always_ff (async low reset) and one always_comb for muxing.

Test Plan:
1. p0 requests addr 0x1000 tag 5, memory acks after 2 cycles and returns 8 beats 0xA0..0xA7 tag 5 -> p0 sees reqack once, receives the 8 beats in order, grant=01 then 00, tag_err=0, p1 outputs stay 0.
2. p0 and p1 both assert reqcyc out of reset -> p0 granted first; after its 8 beats and a 1-cycle gap p1 is granted; repeated for 4 bursts the grants alternate 0,1,0,1.
3. p1 owns the bus and withholds respack on beat 3 for 5 cycles -> m_bus_respack stays 0, beat_cnt holds at 3, and the burst completes after 8 acked beats only.
4. Memory returns tag 7 on beat 2 for a request tagged 4 -> tag_err rises the cycle after beat 2, data is forwarded, and tag_err stays 1 until reset.
5. reset pulled low during beat 4 of a p0 burst -> all outputs 0 asynchronously; after release state=IDLE, and a simultaneous p0/p1 request grants p0.
6. p0 drops reqcyc in REQ before m_bus_reqack -> return to IDLE, no beats routed, and a pending p1 request is granted next.
